// File: rtl/apb_master_nslv.sv
// ---------------------------------------------------------------------------
// apb_master_nslv
//
// Purpose:
//   Single-outstanding APB master that forwards simple request strobes to one
//   of NUM_SLV slaves. The slave is chosen by the top address bits. The
//   master then runs the usual SETUP -> ACCESS handshake and returns a
//   one-cycle completion pulse carrying read data and error status. A wait
//   counter aborts transfers whose slave stalls past TIMEOUT wait cycles.
//
// Ports:
//   PCLK, PRESETn        clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (ready only while idle)
//   req_write/addr/wdata request payload, captured at acceptance
//   rsp_valid            one-cycle completion pulse
//   rsp_rdata/rsp_err    response payload, held until the next completion
//   PSEL..PWDATA         APB request bus, PSEL one-hot per slave
//   PREADY_s/PSLVERR_s   per-slave ready / error returns
//   PRDATA_s             per-slave read data, slave k at [k*DATA_W +: DATA_W]
// ---------------------------------------------------------------------------
module apb_master_nslv #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int NUM_SLV = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [DATA_W-1:0]         req_wdata,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [NUM_SLV-1:0]        PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    input  logic [NUM_SLV-1:0]        PREADY_s,
    input  logic [NUM_SLV-1:0]        PSLVERR_s,
    input  logic [NUM_SLV*DATA_W-1:0] PRDATA_s
);

    localparam int SEL_W = $clog2(NUM_SLV);
    // One spare bit so the counter never wraps even for TIMEOUT = 0.
    localparam int CNT_W = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [SEL_W-1:0]    r_idx;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_paddr;
    logic                r_pwrite;
    logic [DATA_W-1:0]   r_pwdata;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;

    logic                w_accept;
    logic                w_done;
    logic                w_abort;
    logic                w_pready;
    logic                w_pslverr;
    logic [DATA_W-1:0]   w_prdata;
    logic [DATA_W-1:0]   w_prdata_arr [NUM_SLV];

    // Slice the flat read-data bus and decode the one-hot select per slave.
    generate
        for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_slv
            assign w_prdata_arr[gi] = PRDATA_s[gi*DATA_W +: DATA_W];
            assign PSEL[gi]         = (r_state != IDLE) && (r_idx == SEL_W'(gi));
        end
    endgenerate

    assign w_pready  = PREADY_s[r_idx];
    assign w_pslverr = PSLVERR_s[r_idx];
    assign w_prdata  = w_prdata_arr[r_idx];

    // Gated by PRESETn so ready reads 0 while reset is held and rises
    // in the very first cycle after release.
    assign req_ready = (r_state == IDLE) && PRESETn;
    assign w_accept  = req_valid && req_ready;

    assign PENABLE   = (r_state == ACCESS);
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = SETUP;
                end
            end
            SETUP: begin
                w_state_next = ACCESS;
            end
            ACCESS: begin
                // A ready in the final allowed cycle still wins over the abort.
                if (w_pready) begin
                    w_done       = 1'b1;
                    w_state_next = IDLE;
                end else if (r_cnt == CNT_W'(TIMEOUT)) begin
                    w_abort      = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_idx       <= '0;
            r_cnt       <= '0;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_idx    <= req_addr[ADDR_W-1 -: SEL_W];
                r_paddr  <= req_addr;
                r_pwrite <= req_write;
                r_pwdata <= req_wdata;
                r_cnt    <= '0;
            end else if ((r_state == ACCESS) && !w_pready && !w_abort) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            r_rsp_valid <= w_done || w_abort;
            if (w_done) begin
                r_rsp_err   <= w_pslverr;
                r_rsp_rdata <= r_pwrite ? '0 : w_prdata;
            end else if (w_abort) begin
                r_rsp_err   <= 1'b1;
                r_rsp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_nslv.sv
// ---------------------------------------------------------------------------
// tb_apb_master_nslv
//
// Bench for apb_master_nslv. The stimulus process issues requests and pushes
// the expected response (data, error, latency) into a queue. A responder
// plays the slaves and checks the APB request bus. A monitor pops and compares
// every rsp_valid pulse.
// ---------------------------------------------------------------------------
module tb_apb_master_nslv;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int NS = 4;
    localparam int TO = 15;

    logic              PCLK = 1'b0;
    logic              PRESETn;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [AW-1:0]     req_addr;
    logic [DW-1:0]     req_wdata;
    logic              rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic [NS-1:0]     PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [AW-1:0]     PADDR;
    logic [DW-1:0]     PWDATA;
    logic [NS-1:0]     PREADY_s;
    logic [NS-1:0]     PSLVERR_s;
    logic [NS*DW-1:0]  PRDATA_s;

    apb_master_nslv #(.DATA_W(DW), .ADDR_W(AW), .NUM_SLV(NS), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PREADY_s(PREADY_s), .PSLVERR_s(PSLVERR_s), .PRDATA_s(PRDATA_s)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            accept_edge;
        int            lat;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_rsp = 0;

    // Transaction currently owned by the slave model.
    logic [1:0]    cur_idx   = '0;
    logic [AW-1:0] cur_addr  = '0;
    logic          cur_write = 1'b0;
    logic [DW-1:0] cur_wdata = '0;
    int            cur_wait  = 0;
    logic          cur_err   = 1'b0;
    logic [DW-1:0] cur_rdata = '0;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, expv, cyc);
        end
    endtask

    // Slave model: selected slave raises PREADY after cur_wait ACCESS cycles;
    // unselected slaves drive random noise that the master must ignore.
    int seen = 0;
    always @(negedge PCLK) begin
        logic [NS-1:0]    rdy;
        logic [NS-1:0]    er;
        logic [NS*DW-1:0] rd;
        logic [NS-1:0]    onehot;
        rdy = NS'($urandom);
        er  = NS'($urandom);
        rd  = (NS*DW)'($urandom);
        if (PRESETn && PSEL != '0) begin
            onehot = '0;
            onehot[cur_idx] = 1'b1;
            chk("psel_onehot", 64'(PSEL), 64'(onehot));
            chk("paddr", 64'(PADDR), 64'(cur_addr));
            chk("pwrite", 64'(PWRITE), 64'(cur_write));
            chk("pwdata", 64'(PWDATA), 64'(cur_wdata));
            chk("penable_phase", 64'(PENABLE), 64'(seen != 0));
            chk("ready_busy", 64'(req_ready), 64'(0));
            rdy[cur_idx] = PENABLE && ((seen - 1) == cur_wait);
            seen++;
        end else begin
            seen = 0;
        end
        er[cur_idx] = cur_err;
        rd[cur_idx*DW +: DW] = cur_rdata;
        PREADY_s  = rdy;
        PSLVERR_s = er;
        PRDATA_s  = rd;
    end

    // Monitor: every completion pulse must match the oldest outstanding request.
    always @(negedge PCLK) begin
        exp_t e;
        if (PRESETn && rsp_valid) begin
            n_rsp++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp actual=rsp_valid required=no response at cycle %0d", cyc);
            end else begin
                e = exp_q.pop_front();
                $display("rsp %0d: rdata=%02h err=%0d latency=%0d (exp %02h/%0d/%0d)",
                         n_rsp, rsp_rdata, rsp_err, cyc - e.accept_edge, e.rdata, e.err, e.lat);
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                chk("rsp_err", 64'(rsp_err), 64'(e.err));
                chk("rsp_latency", 64'(cyc - e.accept_edge), 64'(e.lat));
            end
        end
    end

    // Issue one request; called just after a falling edge. Wait count w is
    // the number of ACCESS cycles with PREADY low before it rises.
    task automatic issue(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input int w, input bit err, input logic [DW-1:0] rdat, input bit hold);
        bit   got;
        exp_t e;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        got = 0;
        for (int k = 0; k < 300 && !got; k++) begin
            if (req_ready) begin
                got       = 1;
                cur_idx   = addr[AW-1 -: 2];
                cur_addr  = addr;
                cur_write = wr;
                cur_wdata = wd;
                cur_wait  = w;
                cur_err   = err;
                cur_rdata = rdat;
                e.accept_edge = cyc + 1;
                e.lat   = 2 + ((w > TO) ? TO : w);
                e.err   = (w > TO) ? 1'b1 : err;
                e.rdata = ((w > TO) || wr) ? '0 : rdat;
                exp_q.push_back(e);
            end
            @(negedge PCLK);
        end
        if (!got) chk("accept_timeout", 64'(0), 64'(1));
        if (!hold || !got) req_valid = 1'b0;
    endtask

    initial begin
        int w;
        PRESETn   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        #3;
        chk("reset_outputs", 64'({PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, req_ready}), 64'(0));
        @(negedge PCLK);
        @(negedge PCLK);
        #2 PRESETn = 1'b1;
        #1 chk("ready_after_reset", 64'(req_ready), 64'(1));
        @(negedge PCLK);

        // Zero-wait write to slave 2.
        issue(1'b1, 8'h85, 8'h3C, 0, 1'b0, 8'h77, 1'b0);
        repeat (4) @(negedge PCLK);
        // Read from slave 3 after three wait cycles.
        issue(1'b0, 8'hC1, 8'h00, 3, 1'b0, 8'hA5, 1'b0);
        repeat (7) @(negedge PCLK);
        // Slave 0 never ready: timeout abort.
        issue(1'b0, 8'h10, 8'h00, 99, 1'b0, 8'h5A, 1'b0);
        repeat (20) @(negedge PCLK);
        // Ready exactly in the last tolerated cycle completes normally.
        issue(1'b0, 8'h22, 8'h00, TO, 1'b0, 8'h3E, 1'b0);
        repeat (20) @(negedge PCLK);
        // Slave error on a write to slave 1.
        issue(1'b1, 8'h40, 8'h11, 0, 1'b1, 8'h99, 1'b0);
        repeat (4) @(negedge PCLK);

        // Back-to-back with req_valid held high.
        issue(1'b1, 8'h01, 8'hAA, 1, 1'b0, 8'h00, 1'b1);
        issue(1'b0, 8'hF0, 8'h00, 0, 1'b0, 8'hC3, 1'b1);
        issue(1'b0, 8'h7F, 8'h00, 2, 1'b1, 8'h6D, 1'b0);
        repeat (6) @(negedge PCLK);

        // Reset pulse during ACCESS abandons the transfer.
        issue(1'b0, 8'h50, 8'h00, 99, 1'b0, 8'h12, 1'b0);
        for (int k = 0; k < 10 && !PENABLE; k++) @(negedge PCLK);
        chk("reached_access", 64'(PENABLE), 64'(1));
        #1 PRESETn = 1'b0;
        #1 chk("async_reset_outputs", 64'({PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, req_ready}), 64'(0));
        exp_q.delete();
        @(negedge PCLK);
        #1 PRESETn = 1'b1;
        #1 chk("ready_after_midreset", 64'(req_ready), 64'(1));
        @(negedge PCLK);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            w = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 3) : $urandom_range(0, 3);
            issue(1'($urandom), AW'($urandom), DW'($urandom), w, ($urandom_range(0, 3) == 0),
                  DW'($urandom), (t != 39) && 1'($urandom));
            if (!req_valid) repeat ($urandom_range(0, 2)) @(negedge PCLK);
        end
        req_valid = 1'b0;

        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge PCLK);
        chk("drain_outstanding", 64'(exp_q.size()), 64'(0));
        repeat (5) @(negedge PCLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_master_nslv.md
APB_MASTER_NSLV -- requirements
Module: apb_master_nslv

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bus width.
REQ-002 SHALL have parameter ADDR_W, default 8, address width.
REQ-003 SHALL have parameter NUM_SLV, default 4, slave count; power of two, minimum 2.
REQ-004 SHALL have parameter TIMEOUT, default 15, maximum wait cycles tolerated in ACCESS.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: PCLK input 1 clock; PRESETn input 1 async active-low reset.
REQ-006 SHALL have ports: req_valid in 1 request strobe; req_ready out 1 request accepted; req_write in 1 write=1/read=0; req_addr in ADDR_W; req_wdata in DATA_W.
REQ-007 SHALL have ports: rsp_valid out 1 completion pulse; rsp_rdata out DATA_W read data; rsp_err out 1 slave error or timeout.
REQ-008 SHALL have APB ports: PSEL out NUM_SLV one-hot select; PENABLE out 1; PWRITE out 1; PADDR out ADDR_W; PWDATA out DATA_W.
REQ-009 SHALL have slave return ports: PREADY_s in NUM_SLV; PSLVERR_s in NUM_SLV; PRDATA_s in NUM_SLV*DATA_W, slave k at bits [k*DATA_W +: DATA_W].

Function
REQ-010 Slave index SHALL be req_addr[ADDR_W-1 -: log2(NUM_SLV)], registered at acceptance.
REQ-011 FSM states SHALL be IDLE, SETUP, ACCESS.
REQ-012 req_ready SHALL be 1 only in IDLE; acceptance = req_valid & req_ready at a PCLK edge.
REQ-013 On acceptance: PADDR, PWRITE, PWDATA, slave index registered; next state SETUP.
REQ-014 SETUP: PSEL[idx]=1, other PSEL bits 0, PENABLE=0; next state ACCESS unconditionally.
REQ-015 ACCESS: PSEL[idx]=1, PENABLE=1; PADDR/PWRITE/PWDATA held stable for the entire transfer.
REQ-016 In ACCESS, PREADY_s[idx]=1 SHALL complete the transfer; PREADY_s of unselected slaves ignored.
REQ-017 On completion: next state IDLE; next cycle rsp_valid=1 for exactly one cycle, rsp_err=PSLVERR_s[idx], rsp_rdata=PRDATA_s slice idx for reads, 0 for writes.
REQ-018 Wait counter SHALL clear on SETUP entry and increment each ACCESS cycle with PREADY_s[idx]=0.
REQ-019 When counter equals TIMEOUT and PREADY_s[idx]=0, SHALL abort: next state IDLE, PSEL/PENABLE deasserted, rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-020 PREADY_s[idx]=1 in the timeout cycle SHALL count as normal completion, not an abort.
REQ-021 Minimum latency: acceptance edge N -> SETUP cycle N+1 -> ACCESS N+2 -> rsp_valid in cycle N+3; each wait cycle adds one.
REQ-022 rsp_rdata/rsp_err SHALL hold the last response value until the next completion; rsp_valid SHALL be 0 otherwise.
REQ-023 req_valid while req_ready=0 SHALL be ignored; no request queueing.
REQ-024 rsp_valid and acceptance of a new request MAY occur in the same cycle (IDLE).

Reset
REQ-025 PRESETn=0 SHALL immediately force state IDLE, counter 0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0.
REQ-026 req_ready SHALL become 1 in the first cycle after PRESETn deasserts.
REQ-027 Reset during SETUP or ACCESS SHALL abandon the transfer with no rsp_valid.

Verification
REQ-028 Zero-wait write, addr 0x85, data 0x3C, slave 2 PREADY=1 -> PSEL=4'b0100 two cycles, PENABLE in second only; rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
REQ-029 Read addr 0xC1, slave 3 returns 0xA5 after 3 wait cycles -> ACCESS lasts 4 cycles, rsp_rdata=0xA5, rsp_err=0, rsp_valid at N+6.
REQ-030 Read addr 0x10, slave 0 PREADY stuck 0 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0, PSEL returns to 0.
REQ-031 Write addr 0x40, slave 1 PREADY=1 with PSLVERR_s[1]=1 -> rsp_err=1; slave 0 PREADY=1 during transfer has no effect.
REQ-032 PRESETn pulsed low in ACCESS -> all outputs 0 asynchronously, no rsp_valid, req_ready=1 first cycle after release.
REQ-033 Back-to-back requests with req_valid held high -> second acceptance in same cycle as first rsp_valid; req_valid during SETUP/ACCESS not accepted.
